// File: rtl/vga_controller.sv
// 640x480@60 VGA timing generator: a divide-by-two pixel strobe advances the
// horizontal/vertical position counters, and sync/blanking are decoded from them.
module vga_controller #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       rst,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       display_area
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_SYNC_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] V_SYNC_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_SYNC_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       pixel_tick;
    logic       pixel_tick_d;
    logic [9:0] h_counter;
    logic [9:0] h_counter_d;
    logic [9:0] v_counter;
    logic [9:0] v_counter_d;

    // Wrap on ">=" so a counter left out of range recovers on its next advance.
    always_comb begin
        pixel_tick_d = ~pixel_tick;
        h_counter_d  = h_counter;
        v_counter_d  = v_counter;
        if (pixel_tick) begin
            if (h_counter >= H_LAST) begin
                h_counter_d = 10'd0;
                if (v_counter >= V_LAST) begin
                    v_counter_d = 10'd0;
                end else begin
                    v_counter_d = v_counter + 10'd1;
                end
            end else begin
                h_counter_d = h_counter + 10'd1;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            pixel_tick <= 1'b0;
            h_counter  <= 10'd0;
            v_counter  <= 10'd0;
        end else begin
            pixel_tick <= pixel_tick_d;
            h_counter  <= h_counter_d;
            v_counter  <= v_counter_d;
        end
    end

    // Outputs decode the live counters directly, with no output register.
    assign pixel_x      = h_counter;
    assign pixel_y      = v_counter;
    assign display_area = (h_counter < H_VIS_END) && (v_counter < V_VIS_END);
    assign hsync        = !((h_counter >= H_SYNC_FIRST) && (h_counter <= H_SYNC_LAST));
    assign vsync        = !((v_counter >= V_SYNC_FIRST) && (v_counter <= V_SYNC_LAST));

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench for vga_controller: reset state, forced-position decode checks,
// free-running line timing and counter wrap behaviour.
module tb_vga_controller;

    logic       vga_clk;
    logic       rst;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       hsync;
    logic       vsync;
    logic       display_area;

    int checks = 0;
    int errors = 0;

    vga_controller dut (
        .vga_clk      (vga_clk),
        .rst          (rst),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .hsync        (hsync),
        .vsync        (vsync),
        .display_area (display_area)
    );

    initial vga_clk = 1'b0;
    always #10 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic force_pos(input logic [9:0] h, input logic [9:0] v);
        @(negedge vga_clk);
        force dut.h_counter = h;
        force dut.v_counter = v;
        #1;
    endtask

    task automatic release_pos();
        @(negedge vga_clk);
        release dut.h_counter;
        release dut.v_counter;
    endtask

    task automatic edges(input int n);
        for (int i = 0; i < n; i++) @(posedge vga_clk);
        #1;
    endtask

    int n_cyc;
    int low_cyc;
    int h_at_100;
    bit wrapped;

    initial begin
        rst = 1'b1;
        edges(2);
        @(negedge vga_clk);
        rst = 1'b0;
        edges(1);
        check("rst_pixel_x", 32'(pixel_x), 0);
        check("rst_pixel_y", 32'(pixel_y), 0);
        check("rst_display", 32'(display_area), 1);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_tick_set", 32'(dut.pixel_tick), 1);

        // Free-run one full line from reset release.
        n_cyc    = 0;
        low_cyc  = 0;
        h_at_100 = -1;
        wrapped  = 1'b0;
        while (n_cyc < 2000 && !wrapped) begin
            edges(1);
            n_cyc++;
            if (n_cyc == 100) h_at_100 = int'(pixel_x);
            if (hsync == 1'b0) low_cyc++;
            if (pixel_x == 10'd0 && pixel_y == 10'd1) wrapped = 1'b1;
        end
        check("line_wrapped", 32'(wrapped), 1);
        check("line_cycles", 32'(n_cyc), 1599);
        check("h_rate", 32'(h_at_100), 50);
        check("hsync_low_cycles", 32'(low_cyc), 192);

        force_pos(10'd656, 10'd100);
        check("h656_hsync", 32'(hsync), 0);
        check("h656_display", 32'(display_area), 0);
        check("h656_vsync", 32'(vsync), 1);
        force_pos(10'd655, 10'd100);
        check("h655_hsync", 32'(hsync), 1);
        force_pos(10'd751, 10'd100);
        check("h751_hsync", 32'(hsync), 0);
        force_pos(10'd752, 10'd100);
        check("h752_hsync", 32'(hsync), 1);

        force_pos(10'd639, 10'd479);
        check("vis_639_479", 32'(display_area), 1);
        force_pos(10'd640, 10'd479);
        check("vis_640_479", 32'(display_area), 0);
        force_pos(10'd0, 10'd480);
        check("vis_0_480", 32'(display_area), 0);

        force_pos(10'd200, 10'd490);
        check("v490_vsync", 32'(vsync), 0);
        check("v490_display", 32'(display_area), 0);
        check("v490_hsync", 32'(hsync), 1);
        force_pos(10'd200, 10'd491);
        check("v491_vsync", 32'(vsync), 0);
        force_pos(10'd200, 10'd489);
        check("v489_vsync", 32'(vsync), 1);
        force_pos(10'd200, 10'd492);
        check("v492_vsync", 32'(vsync), 1);
        check("v492_pixel_x", 32'(pixel_x), 200);
        check("v492_pixel_y", 32'(pixel_y), 492);

        // Released counters resume from their held contents.
        force_pos(10'd300, 10'd20);
        release_pos();
        edges(2);
        check("resume_h", 32'(pixel_x), 301);
        check("resume_v", 32'(pixel_y), 20);

        force_pos(10'd799, 10'd10);
        release_pos();
        edges(2);
        check("hwrap_h", 32'(pixel_x), 0);
        check("hwrap_v", 32'(pixel_y), 11);

        force_pos(10'd798, 10'd524);
        release_pos();
        edges(2);
        check("pre_frame_h", 32'(pixel_x), 799);
        check("pre_frame_v", 32'(pixel_y), 524);
        edges(2);
        check("frame_wrap_h", 32'(pixel_x), 0);
        check("frame_wrap_v", 32'(pixel_y), 0);

        // Mid-frame reset, applied on an edge where the tick would advance.
        force_pos(10'd400, 10'd300);
        release_pos();
        while (dut.pixel_tick !== 1'b1 && n_cyc < 4000) begin
            edges(1);
            n_cyc++;
        end
        check("tick_found", 32'(dut.pixel_tick), 1);
        @(negedge vga_clk);
        rst = 1'b1;
        edges(1);
        check("midrst_h", 32'(pixel_x), 0);
        check("midrst_v", 32'(pixel_y), 0);
        check("midrst_tick", 32'(dut.pixel_tick), 0);
        check("midrst_display", 32'(display_area), 1);
        @(negedge vga_clk);
        rst = 1'b0;
        edges(1);
        check("post_rst_h", 32'(pixel_x), 0);
        edges(1);
        check("post_rst_adv", 32'(pixel_x), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
